// File: rtl/hetic_pkg.sv
// Shared types and sizing for the HETIC nesting controller.
// Optional build macro HETIC_NEST_THRESHOLD_EN is consumed by hetic_nest_ctrl.
package hetic_pkg;

  localparam int unsigned NrIrqLines = 64;
  localparam int unsigned NrIrqPrios = 32;
  localparam int unsigned StackDepth = 8;

  localparam int unsigned IrqWidth   = $clog2(NrIrqLines);
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios);
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1);

  typedef struct packed {
    logic [PrioWidth-1:0] level;
    logic                 nest;
  } nest_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/hetic_level_stack.sv
// LIFO of preempted contexts; simultaneous push+pop replaces the top,
// pop on empty is ignored and latches a sticky underflow flag.
module hetic_level_stack #(
  parameter int unsigned Width  = 6,
  parameter int unsigned Depth  = 8,
  parameter int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [Width-1:0]  data_i,
  output logic [Width-1:0]  top_o,
  output logic [DepthW-1:0] depth_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              underflow_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [DepthW-1:0] depth_q;
  logic              underflow_q;
  logic [IdxW-1:0]   top_idx;
  logic [IdxW-1:0]   wr_idx;
  logic              do_pop;

  assign empty_o     = (depth_q == '0);
  assign full_o      = (depth_q == DepthW'(Depth));
  assign depth_o     = depth_q;
  assign underflow_o = underflow_q;
  assign top_idx     = IdxW'(depth_q - 1'b1);
  assign wr_idx      = IdxW'(depth_q);
  assign do_pop      = pop_i && !empty_o;
  assign top_o       = empty_o ? '0 : mem_q[top_idx];

  // NOTE: the storage is reset along with the pointer because the whole
  // controller must come out of reset in a fully cleared state; it is tiny.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      depth_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (pop_i && empty_o) underflow_q <= 1'b1;
      if (push_i && do_pop) begin
        mem_q[top_idx] <= data_i;
      end else if (push_i && !full_o) begin
        mem_q[wr_idx] <= data_i;
        depth_q       <= depth_q + 1'b1;
      end else if (do_pop) begin
        depth_q <= depth_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hetic_nest_ctrl.sv
// Preemption gate between HETIC and the core, with a nesting stack.
// Define HETIC_NEST_THRESHOLD_EN to add a thresh_i priority floor.
module hetic_nest_ctrl
  import hetic_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  irq_valid_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0]  irq_level_i,
  input  logic                  irq_heti_i,
  input  logic                  irq_nest_i,
  output logic                  irq_ack_o,
  output logic [IrqWidth-1:0]   irq_id_o,
  output logic                  core_irq_req_o,
  output logic [IrqWidth-1:0]   core_irq_id_o,
  output logic [PrioWidth-1:0]  core_irq_level_o,
  output logic                  core_irq_heti_o,
  input  logic                  core_irq_ack_i,
  input  logic                  core_mret_i,
`ifdef HETIC_NEST_THRESHOLD_EN
  input  logic [PrioWidth-1:0]  thresh_i,
`endif
  output logic [PrioWidth-1:0]  cur_level_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  underflow_o
);

  state_e               state_q, state_d;
  logic [IrqWidth-1:0]  req_id_q;
  logic [PrioWidth-1:0] req_level_q;
  logic                 req_heti_q;
  logic                 req_nest_q;
  logic                 load;
  logic                 push;
  logic                 eligible;
  logic                 stk_empty;
  logic                 stk_full;
  logic [PrioWidth-1:0] floor_level;
  nest_entry_t          top_entry;
  nest_entry_t          push_entry;

  hetic_level_stack #(
    .Width  ($bits(nest_entry_t)),
    .Depth  (StackDepth),
    .DepthW (DepthWidth)
  ) u_stack (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .pop_i       (core_mret_i),
    .data_i      (push_entry),
    .top_o       (top_entry),
    .depth_o     (depth_o),
    .empty_o     (stk_empty),
    .full_o      (stk_full),
    .underflow_o (underflow_o)
  );

  // The stack top reads zero when empty, so thread level falls out as 0.
  assign cur_level_o = top_entry.level;

`ifdef HETIC_NEST_THRESHOLD_EN
  assign floor_level = (cur_level_o > thresh_i) ? cur_level_o : thresh_i;
`else
  assign floor_level = cur_level_o;
`endif

  assign eligible = irq_valid_i
                 && (irq_level_i > floor_level)
                 && (stk_empty || top_entry.nest)
                 && !stk_full;

  assign push_entry = '{level: req_level_q, nest: req_nest_q};

  // NOTE: every output of this block gets a default first so that no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    push      = 1'b0;
    irq_ack_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (core_irq_ack_i) begin
          irq_ack_o = 1'b1;
          push      = 1'b1;
          state_d   = IDLE;
        end else if (eligible) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_id_q    <= '0;
      req_level_q <= '0;
      req_heti_q  <= 1'b0;
      req_nest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        req_id_q    <= irq_id_i;
        req_level_q <= irq_level_i;
        req_heti_q  <= irq_heti_i;
        req_nest_q  <= irq_nest_i;
      end
    end
  end

  assign core_irq_req_o   = (state_q == REQ);
  assign core_irq_id_o    = req_id_q;
  assign core_irq_level_o = req_level_q;
  assign core_irq_heti_o  = req_heti_q;
  assign irq_id_o         = req_id_q;

endmodule

// File: tb/tb_hetic_nest_ctrl.sv
// Directed bench for hetic_nest_ctrl (default build, threshold disabled).
module tb_hetic_nest_ctrl;
  import hetic_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  irq_valid_i;
  logic [IrqWidth-1:0]   irq_id_i;
  logic [PrioWidth-1:0]  irq_level_i;
  logic                  irq_heti_i;
  logic                  irq_nest_i;
  logic                  irq_ack_o;
  logic [IrqWidth-1:0]   irq_id_o;
  logic                  core_irq_req_o;
  logic [IrqWidth-1:0]   core_irq_id_o;
  logic [PrioWidth-1:0]  core_irq_level_o;
  logic                  core_irq_heti_o;
  logic                  core_irq_ack_i;
  logic                  core_mret_i;
  logic [PrioWidth-1:0]  cur_level_o;
  logic [DepthWidth-1:0] depth_o;
  logic                  underflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hetic_nest_ctrl dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .irq_valid_i      (irq_valid_i),
    .irq_id_i         (irq_id_i),
    .irq_level_i      (irq_level_i),
    .irq_heti_i       (irq_heti_i),
    .irq_nest_i       (irq_nest_i),
    .irq_ack_o        (irq_ack_o),
    .irq_id_o         (irq_id_o),
    .core_irq_req_o   (core_irq_req_o),
    .core_irq_id_o    (core_irq_id_o),
    .core_irq_level_o (core_irq_level_o),
    .core_irq_heti_o  (core_irq_heti_o),
    .core_irq_ack_i   (core_irq_ack_i),
    .core_mret_i      (core_mret_i),
    .cur_level_o      (cur_level_o),
    .depth_o          (depth_o),
    .underflow_o      (underflow_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input int id, input int lvl, input logic nest);
    irq_valid_i = v;
    irq_id_i    = IrqWidth'(id);
    irq_level_i = PrioWidth'(lvl);
    irq_heti_i  = 1'b0;
    irq_nest_i  = nest;
  endtask

  // Take one interrupt end-to-end: request, then ack, then HETIC drops valid.
  task automatic take(input int id, input int lvl, input logic nest);
    drive(1'b1, id, lvl, nest);
    tick();
    core_irq_ack_i = 1'b1;
    tick();
    core_irq_ack_i = 1'b0;
    irq_valid_i    = 1'b0;
  endtask

  task automatic mret_n(input int n);
    core_mret_i = 1'b1;
    repeat (n) tick();
    core_mret_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    core_irq_ack_i = 1'b0;
    core_mret_i    = 1'b0;
    settle();
    check("rst_req", core_irq_req_o, 0);
    check("rst_ack", irq_ack_o, 0);
    check("rst_cur", cur_level_o, 0);
    check("rst_depth", depth_o, 0);
    check("rst_uflow", underflow_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic take
    drive(1'b1, 5, 3, 1'b1);
    irq_heti_i = 1'b1;
    settle();
    check("basic_req_not_same_cycle", core_irq_req_o, 0);
    tick();
    check("basic_req", core_irq_req_o, 1);
    check("basic_id", core_irq_id_o, 5);
    check("basic_level", core_irq_level_o, 3);
    check("basic_heti", core_irq_heti_o, 1);
    check("basic_no_early_ack", irq_ack_o, 0);
    core_irq_ack_i = 1'b1;
    settle();
    check("basic_ack", irq_ack_o, 1);
    check("basic_ack_id", irq_id_o, 5);
    tick();
    core_irq_ack_i = 1'b0;
    irq_valid_i    = 1'b0;
    check("basic_cur", cur_level_o, 3);
    check("basic_depth", depth_o, 1);
    check("basic_req_drop", core_irq_req_o, 0);

    // Preemption and unwind
    take(9, 7, 1'b1);
    check("pre_cur", cur_level_o, 7);
    check("pre_depth", depth_o, 2);
    mret_n(1);
    check("unw1_cur", cur_level_o, 3);
    check("unw1_depth", depth_o, 1);
    mret_n(1);
    check("unw2_cur", cur_level_o, 0);
    check("unw2_depth", depth_o, 0);

    // No preemption of a non-nestable handler
    take(4, 3, 1'b0);
    drive(1'b1, 10, 7, 1'b1);
    tick();
    check("nonest_req", core_irq_req_o, 0);
    tick();
    check("nonest_req2", core_irq_req_o, 0);
    core_mret_i = 1'b1;
    tick();
    core_mret_i = 1'b0;
    check("nonest_after_mret", core_irq_req_o, 0);
    check("nonest_cur0", cur_level_o, 0);
    tick();
    check("nonest_req_now", core_irq_req_o, 1);
    check("nonest_id", core_irq_id_o, 10);

    // Withdrawal before ack
    irq_valid_i = 1'b0;
    settle();
    check("wd_no_ack", irq_ack_o, 0);
    tick();
    check("wd_req_fall", core_irq_req_o, 0);
    check("wd_depth", depth_o, 0);

    // Equal level does not preempt
    take(5, 3, 1'b1);
    drive(1'b1, 6, 3, 1'b1);
    tick();
    check("eq_no_req", core_irq_req_o, 0);

    // Re-arbitration while requesting
    drive(1'b1, 5, 4, 1'b1);
    tick();
    check("rearb_req", core_irq_req_o, 1);
    check("rearb_id0", core_irq_id_o, 5);
    drive(1'b1, 9, 6, 1'b1);
    tick();
    check("rearb_req_held", core_irq_req_o, 1);
    check("rearb_id1", core_irq_id_o, 9);
    check("rearb_lvl1", core_irq_level_o, 6);
    core_irq_ack_i = 1'b1;
    settle();
    check("rearb_ack_id", irq_id_o, 9);
    tick();
    core_irq_ack_i = 1'b0;
    irq_valid_i    = 1'b0;
    check("rearb_cur", cur_level_o, 6);
    check("rearb_depth", depth_o, 2);
    mret_n(2);
    check("rearb_unw", depth_o, 0);

    // Simultaneous mret and ack replaces the top
    take(2, 2, 1'b1);
    drive(1'b1, 11, 5, 1'b1);
    tick();
    core_irq_ack_i = 1'b1;
    core_mret_i    = 1'b1;
    tick();
    core_irq_ack_i = 1'b0;
    core_mret_i    = 1'b0;
    irq_valid_i    = 1'b0;
    check("swap_depth", depth_o, 1);
    check("swap_cur", cur_level_o, 5);
    mret_n(1);
    check("swap_unw", depth_o, 0);
    check("swap_uflow", underflow_o, 0);

    // Depth limit
    for (int l = 1; l <= 8; l++) take(l, l, 1'b1);
    check("full_depth", depth_o, 8);
    check("full_cur", cur_level_o, 8);
    drive(1'b1, 20, 9, 1'b1);
    tick();
    check("full_no_req", core_irq_req_o, 0);
    mret_n(1);
    check("full_pop_cur", cur_level_o, 7);
    tick();
    check("full_req", core_irq_req_o, 1);
    check("full_req_id", core_irq_id_o, 20);
    irq_valid_i = 1'b0;
    tick();
    mret_n(7);
    check("drain_depth", depth_o, 0);
    check("drain_uflow", underflow_o, 0);
    mret_n(1);
    check("uflow_set", underflow_o, 1);
    check("uflow_depth", depth_o, 0);
    tick();
    check("uflow_sticky", underflow_o, 1);

    // Async reset in REQ with depth 3
    take(1, 1, 1'b1);
    take(2, 2, 1'b1);
    take(3, 3, 1'b1);
    drive(1'b1, 12, 4, 1'b1);
    tick();
    check("prerst_req", core_irq_req_o, 1);
    check("prerst_depth", depth_o, 3);
    #2;
    core_irq_ack_i = 1'b1;
    rst_ni         = 1'b0;
    #1;
    check("arst_req", core_irq_req_o, 0);
    check("arst_ack", irq_ack_o, 0);
    check("arst_id", irq_id_o, 0);
    check("arst_cur", cur_level_o, 0);
    check("arst_depth", depth_o, 0);
    check("arst_uflow", underflow_o, 0);
    tick();
    check("arst_hold_ack", irq_ack_o, 0);
    check("arst_hold_depth", depth_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
